// File: rtl/wb_sequencer.sv
// Writeback sequencer: turns per-instruction writeback commands into the
// MemToReg mux select, register-file write enable and address, with a load timeout.
module wb_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [1:0] issue_src,
    input  logic [4:0] issue_rd,
    output logic       issue_ready,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic [1:0] wb_sel,
    output logic       reg_write,
    output logic [4:0] wb_rd,
    output logic       stall,
    output logic       mem_err,
    output logic       src_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WB       = 2'd2
    } state_t;

    localparam logic [1:0]       SRC_ALU  = 2'b00;
    localparam logic [1:0]       SRC_MEM  = 2'b01;
    localparam logic [1:0]       SRC_LINK = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic [1:0]       sel_next;
    logic [4:0]       rd_next;
    logic             write_next, req_next, merr_next, serr_next;

    // Only the load wait blocks new commands; WB can accept a follow-on command.
    assign issue_ready = (state != MEM_WAIT);
    assign stall       = ~issue_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            wb_sel    <= SRC_ALU;
            wb_rd     <= '0;
            reg_write <= 1'b0;
            mem_req   <= 1'b0;
            mem_err   <= 1'b0;
            src_err   <= 1'b0;
        end else begin
            state     <= state_next;
            counter   <= counter_next;
            wb_sel    <= sel_next;
            wb_rd     <= rd_next;
            reg_write <= write_next;
            mem_req   <= req_next;
            mem_err   <= merr_next;
            src_err   <= serr_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        sel_next     = wb_sel;
        rd_next      = wb_rd;
        write_next   = 1'b0;
        req_next     = 1'b0;
        merr_next    = 1'b0;
        serr_next    = 1'b0;

        case (state)
            IDLE, WB: begin
                state_next = IDLE;
                if (issue_valid) begin
                    case (issue_src)
                        SRC_ALU, SRC_LINK: begin
                            state_next = WB;
                            sel_next   = issue_src;
                            rd_next    = issue_rd;
                            write_next = (issue_rd != 5'd0);
                        end
                        SRC_MEM: begin
                            state_next   = MEM_WAIT;
                            sel_next     = SRC_MEM;
                            rd_next      = issue_rd;
                            counter_next = '0;
                            req_next     = 1'b1;
                        end
                        default: begin
                            state_next = IDLE;
                            serr_next  = 1'b1;
                        end
                    endcase
                end
            end
            MEM_WAIT: begin
                // A ready arriving on the final allowed cycle still completes the load.
                if (mem_ready) begin
                    state_next = WB;
                    write_next = (wb_rd != 5'd0);
                end else if (counter == CNT_LAST) begin
                    state_next = IDLE;
                    merr_next  = 1'b1;
                end else begin
                    counter_next = counter + 1'b1;
                    req_next     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed scenarios followed by random
// traffic, all compared against a transaction-level expectation model.
module tb_wb_sequencer;

    localparam int MEM_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0;
    logic [1:0] issue_src = 2'b00;
    logic [4:0] issue_rd = 5'd0;
    logic       mem_ready = 1'b0;
    logic       issue_ready, mem_req, reg_write, stall, mem_err, src_err;
    logic [1:0] wb_sel;
    logic [4:0] wb_rd;

    wb_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_src(issue_src), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .mem_ready(mem_ready), .mem_req(mem_req),
        .wb_sel(wb_sel), .reg_write(reg_write), .wb_rd(wb_rd),
        .stall(stall), .mem_err(mem_err), .src_err(src_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expectation model: wait_age is the number of load-wait cycles already
    // spent on the outstanding load, or -1 when no load is outstanding.
    int         wait_age = -1;
    bit         known    = 1'b0;
    logic [1:0] e_sel    = 2'b00;
    logic [4:0] e_rd     = 5'd0;
    logic       e_write  = 1'b0;
    logic       e_req    = 1'b0;
    logic       e_merr   = 1'b0;
    logic       e_serr   = 1'b0;

    int cnt_req, cnt_merr, cnt_serr, cnt_write, cnt_stall;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        e_write = 1'b0;
        e_req   = 1'b0;
        e_merr  = 1'b0;
        e_serr  = 1'b0;
        if (rst) begin
            wait_age = -1;
            e_sel    = 2'b00;
            e_rd     = 5'd0;
            known    = 1'b1;
        end else if (wait_age >= 0) begin
            if (mem_ready) begin
                e_write  = (e_rd != 5'd0);
                wait_age = -1;
            end else if (wait_age + 1 == MEM_TIMEOUT) begin
                e_merr   = 1'b1;
                wait_age = -1;
            end else begin
                wait_age++;
                e_req = 1'b1;
            end
        end else if (issue_valid) begin
            if (issue_src == 2'b00 || issue_src == 2'b10) begin
                e_sel   = issue_src;
                e_rd    = issue_rd;
                e_write = (issue_rd != 5'd0);
            end else if (issue_src == 2'b01) begin
                e_sel    = 2'b01;
                e_rd     = issue_rd;
                wait_age = 0;
                e_req    = 1'b1;
            end else begin
                e_serr = 1'b1;
            end
        end
    endtask

    // One clock cycle: drive inputs, check handshake before the edge, check registers after it.
    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] s,
                                 input logic [4:0] d, input logic mr);
        @(negedge clk);
        rst = r; issue_valid = v; issue_src = s; issue_rd = d; mem_ready = mr;
        #1;
        if (known) begin
            checkOutput("issue_ready", 8'(issue_ready), 8'(wait_age < 0));
            checkOutput("stall", 8'(stall), 8'(wait_age >= 0));
        end
        if (stall === 1'b1) cnt_stall++;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("wb_sel", 8'(wb_sel), 8'(e_sel));
        checkOutput("wb_rd", 8'(wb_rd), 8'(e_rd));
        checkOutput("reg_write", 8'(reg_write), 8'(e_write));
        checkOutput("mem_req", 8'(mem_req), 8'(e_req));
        checkOutput("mem_err", 8'(mem_err), 8'(e_merr));
        checkOutput("src_err", 8'(src_err), 8'(e_serr));
        if (mem_req === 1'b1)   cnt_req++;
        if (mem_err === 1'b1)   cnt_merr++;
        if (src_err === 1'b1)   cnt_serr++;
        if (reg_write === 1'b1) cnt_write++;
    endtask

    task automatic clearCounts();
        cnt_req = 0; cnt_merr = 0; cnt_serr = 0; cnt_write = 0; cnt_stall = 0;
    endtask

    initial begin
        clearCounts();

        // Reset and reset values
        applyStimulus(1, 0, 2'b00, 5'd0, 0);
        applyStimulus(1, 0, 2'b00, 5'd0, 0);
        checkOutput("rst_reg_write", 8'(reg_write), 8'd0);
        checkOutput("rst_wb_rd", 8'(wb_rd), 8'd0);
        applyStimulus(0, 0, 2'b00, 5'd0, 0);

        // ALU rd=5
        applyStimulus(0, 1, 2'b00, 5'd5, 0);
        checkOutput("t1_sel", 8'(wb_sel), 8'd0);
        checkOutput("t1_write", 8'(reg_write), 8'd1);
        checkOutput("t1_rd", 8'(wb_rd), 8'd5);
        applyStimulus(0, 0, 2'b00, 5'd0, 0);

        // LINK rd=31 then ALU rd=3 back to back
        applyStimulus(0, 1, 2'b10, 5'd31, 0);
        checkOutput("t2_sel_link", 8'(wb_sel), 8'd2);
        checkOutput("t2_write_link", 8'(reg_write), 8'd1);
        applyStimulus(0, 1, 2'b00, 5'd3, 0);
        checkOutput("t2_sel_alu", 8'(wb_sel), 8'd0);
        checkOutput("t2_write_alu", 8'(reg_write), 8'd1);
        applyStimulus(0, 0, 2'b00, 5'd0, 0);

        // MEM rd=7, ready on the third wait cycle
        applyStimulus(0, 1, 2'b01, 5'd7, 0);
        clearCounts();
        applyStimulus(0, 0, 2'b00, 5'd0, 0);
        applyStimulus(0, 0, 2'b00, 5'd0, 0);
        applyStimulus(0, 0, 2'b00, 5'd0, 1);
        checkOutput("t3_stall_cycles", 8'(cnt_stall), 8'd3);
        checkOutput("t3_write", 8'(reg_write), 8'd1);
        checkOutput("t3_sel", 8'(wb_sel), 8'd1);
        checkOutput("t3_rd", 8'(wb_rd), 8'd7);
        applyStimulus(0, 0, 2'b00, 5'd0, 0);

        // MEM rd=8 with no ready: timeout
        clearCounts();
        applyStimulus(0, 1, 2'b01, 5'd8, 0);
        for (int i = 0; i < MEM_TIMEOUT + 2; i++) applyStimulus(0, 0, 2'b00, 5'd0, 0);
        checkOutput("t4_req_cycles", 8'(cnt_req), 8'(MEM_TIMEOUT));
        checkOutput("t4_err_pulses", 8'(cnt_merr), 8'd1);
        checkOutput("t4_writes", 8'(cnt_write), 8'd0);

        // Ready on the last allowed wait cycle wins over the timeout
        clearCounts();
        applyStimulus(0, 1, 2'b01, 5'd9, 0);
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) applyStimulus(0, 0, 2'b00, 5'd0, 0);
        applyStimulus(0, 0, 2'b00, 5'd0, 1);
        applyStimulus(0, 0, 2'b00, 5'd0, 0);
        checkOutput("t5_writes", 8'(cnt_write), 8'd1);
        checkOutput("t5_err_pulses", 8'(cnt_merr), 8'd0);
        applyStimulus(0, 1, 2'b00, 5'd0, 0);
        checkOutput("t5_r0_write", 8'(reg_write), 8'd0);

        // Reset in the middle of a load wait, then an illegal source
        applyStimulus(0, 1, 2'b01, 5'd4, 0);
        applyStimulus(0, 0, 2'b00, 5'd0, 0);
        applyStimulus(1, 0, 2'b00, 5'd0, 1);
        checkOutput("t6_rst_req", 8'(mem_req), 8'd0);
        checkOutput("t6_rst_write", 8'(reg_write), 8'd0);
        checkOutput("t6_rst_err", 8'(mem_err), 8'd0);
        applyStimulus(0, 0, 2'b00, 5'd0, 0);
        checkOutput("t6_ready_after_rst", 8'(issue_ready), 8'd1);
        clearCounts();
        applyStimulus(0, 1, 2'b11, 5'd12, 0);
        checkOutput("t6_src_err", 8'(src_err), 8'd1);
        checkOutput("t6_src_write", 8'(reg_write), 8'd0);
        applyStimulus(0, 0, 2'b00, 5'd0, 0);
        checkOutput("t6_src_err_pulses", 8'(cnt_serr), 8'd1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic       r_rst, r_valid, r_ready;
            logic [1:0] r_src;
            logic [4:0] r_rd;
            r_rst   = ($urandom_range(0, 39) == 0);
            r_valid = ($urandom_range(0, 9) < 7);
            r_src   = 2'($urandom_range(0, 3));
            r_rd    = 5'($urandom_range(0, 31));
            r_ready = ($urandom_range(0, 9) < 2);
            applyStimulus(r_rst, r_valid, r_src, r_rd, r_ready);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
